// File: rtl/crossing_pkg.sv
// Shared types and constants for the pedestrian-crossing sequencer.
// Phase enum, light codes, default phase lengths and a width helper.
package crossing_pkg;

    typedef enum logic [1:0] {
        GREEN     = 2'd0,
        AMBER     = 2'd1,
        RED_WALK  = 2'd2,
        RED_AMBER = 2'd3
    } phase_t;

    // Light code is {red, amber, green}
    localparam logic [2:0] LIGHT_GREEN     = 3'b001;
    localparam logic [2:0] LIGHT_AMBER     = 3'b010;
    localparam logic [2:0] LIGHT_RED       = 3'b100;
    localparam logic [2:0] LIGHT_RED_AMBER = 3'b110;

    localparam int DEFAULT_GREEN_MIN        = 8;
    localparam int DEFAULT_AMBER_CYCLES     = 2;
    localparam int DEFAULT_WALK_CYCLES      = 6;
    localparam int DEFAULT_RED_AMBER_CYCLES = 1;

    // Bits needed to count 0 .. longest-phase - 1, never less than one.
    function automatic int timer_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/crossing_controller_phase_timer.sv
// Per-phase cycle timer: synchronous clear, increment enable, optional
// saturation at the runtime limit, and a done flag when count == limit.
module phase_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             saturate,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    logic [WIDTH-1:0] count_reg;

    assign count = count_reg;
    assign done  = (count_reg == limit);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (enable && !(saturate && done)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/crossing_controller.sv
// Pedestrian-crossing sequencer: GREEN -> AMBER -> RED_WALK -> RED_AMBER.
// Define CROSSING_STATS_EN to add the 8-bit wrapping cross_count output.
module crossing_controller
    import crossing_pkg::*;
#(
    parameter int GREEN_MIN        = DEFAULT_GREEN_MIN,
    parameter int AMBER_CYCLES     = DEFAULT_AMBER_CYCLES,
    parameter int WALK_CYCLES      = DEFAULT_WALK_CYCLES,
    parameter int RED_AMBER_CYCLES = DEFAULT_RED_AMBER_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    output logic [2:0] result,
    output logic       walk,
    output logic       req_pending,
    output logic       busy
`ifdef CROSSING_STATS_EN
    ,
    output logic [7:0] cross_count
`endif
);

    localparam int TIMER_W = timer_width(GREEN_MIN, AMBER_CYCLES, WALK_CYCLES, RED_AMBER_CYCLES);

    // Exit values: each phase leaves when the timer reaches length - 1.
    localparam logic [TIMER_W-1:0] LAST_GREEN     = TIMER_W'(GREEN_MIN - 1);
    localparam logic [TIMER_W-1:0] LAST_AMBER     = TIMER_W'(AMBER_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LAST_WALK      = TIMER_W'(WALK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LAST_RED_AMBER = TIMER_W'(RED_AMBER_CYCLES - 1);

    phase_t             state_reg;
    phase_t             state_next;
    logic               req_pending_reg;
    logic               req_pending_next;
    logic [TIMER_W-1:0] timer_limit;
    logic [TIMER_W-1:0] timer_count;
    logic               timer_done;
    logic               timer_clear;
    logic               enter_walk;

    phase_timer #(
        .WIDTH(TIMER_W)
    ) u_phase_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (1'b1),
        .saturate(state_reg == GREEN),
        .limit   (timer_limit),
        .count   (timer_count),
        .done    (timer_done)
    );

    always_comb begin
        state_next  = state_reg;
        timer_limit = LAST_GREEN;
        case (state_reg)
            GREEN: begin
                timer_limit = LAST_GREEN;
                if ((timer_count == LAST_GREEN) && (req_pending_reg || button)) begin
                    state_next = AMBER;
                end
            end
            AMBER: begin
                timer_limit = LAST_AMBER;
                if (timer_done) state_next = RED_WALK;
            end
            RED_WALK: begin
                timer_limit = LAST_WALK;
                if (timer_done) state_next = RED_AMBER;
            end
            RED_AMBER: begin
                timer_limit = LAST_RED_AMBER;
                if (timer_done) state_next = GREEN;
            end
            default: begin
                state_next = GREEN;
            end
        endcase
    end

    assign timer_clear = (state_next != state_reg);
    assign enter_walk  = (state_reg == AMBER) && (state_next == RED_WALK);

    // Serving the request (entering RED_WALK) beats a press on the same edge.
    always_comb begin
        req_pending_next = req_pending_reg;
        if (enter_walk) begin
            req_pending_next = 1'b0;
        end else if (button && (state_reg == GREEN || state_reg == AMBER)) begin
            req_pending_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= GREEN;
            req_pending_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            req_pending_reg <= req_pending_next;
        end
    end

    always_comb begin
        result = LIGHT_GREEN;
        case (state_reg)
            GREEN:     result = LIGHT_GREEN;
            AMBER:     result = LIGHT_AMBER;
            RED_WALK:  result = LIGHT_RED;
            RED_AMBER: result = LIGHT_RED_AMBER;
            default:   result = LIGHT_GREEN;
        endcase
    end

    assign walk        = (state_reg == RED_WALK);
    assign busy        = (state_reg != GREEN);
    assign req_pending = req_pending_reg;

`ifdef CROSSING_STATS_EN
    logic [7:0] cross_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cross_count_reg <= 8'd0;
        end else if (enter_walk) begin
            cross_count_reg <= cross_count_reg + 8'd1;
        end
    end

    assign cross_count = cross_count_reg;
`endif

endmodule
